// File: rtl/lzy_lab_pkg.sv
// Shared types and helpers for the JK flip-flop lab stimulus controllers.
package lzy_lab_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DEB_REL
  } state_t;

  // Bits needed for a counter that runs 0..max(a,b)-1; never narrower than 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lzy_sync2.sv
// Multi-flop synchroniser for an asynchronous lab input, with a selectable reset level.
module lzy_sync2
  import lzy_lab_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) stages <= {SYNC_STAGES{RST_VAL}};
    else     stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/lzy_jk_step_ctrl.sv
// Debounced push key to single fixed-width Step pulse for the lab JK flip-flop,
// with J/K frozen around each pulse and Sd/Rd passed straight through.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for key press
// DEB_PRESS  | key low, counting stable cycles before accepting the press
// SETUP      | J/K just latched; one cycle of setup before Step rises
// PULSE      | Step high for PULSE_W cycles
// HOLD       | pulse done, waiting for key release
// DEB_REL    | key high, counting stable cycles before accepting release
module lzy_jk_step_ctrl
  import lzy_lab_pkg::*;
#(
  parameter int DEB_CYCLES = 8,
  parameter int PULSE_W    = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Key_n,
  input  logic             Sw_J,
  input  logic             Sw_K,
  input  logic             Sw_Sd,
  input  logic             Sw_Rd,
  output logic             Step,
  output logic             J,
  output logic             K,
  output logic             Sd,
  output logic             Rd,
  output logic             Busy,
  output logic [CNT_W-1:0] Press_cnt
);

  localparam int CW = cnt_width(DEB_CYCLES, PULSE_W);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);

  logic key_s;
  logic j_s;
  logic k_s;
  state_t state;
  logic [CW-1:0] cnt;

  lzy_sync2 #(.RST_VAL(1'b1)) u_sync_key (.clk(Clk), .rst(Rst), .d(Key_n), .q(key_s));
  lzy_sync2 #(.RST_VAL(1'b0)) u_sync_j   (.clk(Clk), .rst(Rst), .d(Sw_J),  .q(j_s));
  lzy_sync2 #(.RST_VAL(1'b0)) u_sync_k   (.clk(Clk), .rst(Rst), .d(Sw_K),  .q(k_s));
  lzy_sync2 #(.RST_VAL(1'b1)) u_sync_sd  (.clk(Clk), .rst(Rst), .d(Sw_Sd), .q(Sd));
  lzy_sync2 #(.RST_VAL(1'b1)) u_sync_rd  (.clk(Clk), .rst(Rst), .d(Sw_Rd), .q(Rd));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      Step      <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      Busy      <= 1'b0;
      Press_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!key_s) begin
            state <= ST_DEB_PRESS;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        ST_DEB_PRESS: begin
          if (key_s) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            // J/K change here so they settle a full cycle before Step rises.
            state <= ST_SETUP;
            J     <= j_s;
            K     <= k_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SETUP: begin
          state     <= ST_PULSE;
          Step      <= 1'b1;
          cnt       <= '0;
          Press_cnt <= Press_cnt + CNT_W'(1);
        end
        ST_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= ST_HOLD;
            Step  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (key_s) begin
            state <= ST_DEB_REL;
            cnt   <= '0;
          end
        end
        ST_DEB_REL: begin
          if (!key_s) begin
            state <= ST_HOLD;
          end else if (cnt == DEB_LAST) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          Step  <= 1'b0;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzy_jk_step_ctrl.sv
// Scoreboard bench: driver predicts each accepted press, monitor checks every Step pulse.
module tb_lzy_jk_step_ctrl;

  localparam int DEB = 8;
  localparam int PW  = 4;

  logic Clk = 1'b0, Rst = 1'b1, Key_n = 1'b1;
  logic Sw_J = 1'b0, Sw_K = 1'b0, Sw_Sd = 1'b1, Sw_Rd = 1'b1;
  logic Step, J, K, Sd, Rd, Busy;
  logic [7:0] Press_cnt;
  logic Step2, J2, K2, Sd2, Rd2, Busy2;
  logic [1:0] Press_cnt2;

  lzy_jk_step_ctrl #(.DEB_CYCLES(DEB), .PULSE_W(PW), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Key_n(Key_n), .Sw_J(Sw_J), .Sw_K(Sw_K),
    .Sw_Sd(Sw_Sd), .Sw_Rd(Sw_Rd), .Step(Step), .J(J), .K(K), .Sd(Sd),
    .Rd(Rd), .Busy(Busy), .Press_cnt(Press_cnt));

  lzy_jk_step_ctrl #(.DEB_CYCLES(DEB), .PULSE_W(PW), .CNT_W(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .Key_n(Key_n), .Sw_J(Sw_J), .Sw_K(Sw_K),
    .Sw_Sd(Sw_Sd), .Sw_Rd(Sw_Rd), .Step(Step2), .J(J2), .K(K2), .Sd(Sd2),
    .Rd(Rd2), .Busy(Busy2), .Press_cnt(Press_cnt2));

  always #5 Clk = ~Clk;

  typedef struct {
    logic j;
    logic k;
    int   cnt;
    int   rise;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  bit   aborted = 0;
  bit   sw_go = 0;

  always @(posedge Clk) cyc++;

  // Expected Sd/Rd: raw switch as sampled one edge before the latest edge.
  logic h_sd1 = 1'b1, h_sd2 = 1'b1, h_rd1 = 1'b1, h_rd2 = 1'b1;
  always @(posedge Clk) begin
    if (Rst) begin
      h_sd1 = 1'b1; h_sd2 = 1'b1; h_rd1 = 1'b1; h_rd2 = 1'b1;
    end else begin
      h_sd2 = h_sd1; h_sd1 = Sw_Sd;
      h_rd2 = h_rd1; h_rd1 = Sw_Rd;
    end
  end

  initial begin
    wait (sw_go);
    forever begin
      @(posedge Clk); #1;
      if ($urandom_range(0, 5) == 0) Sw_Sd = ~Sw_Sd;
      if ($urandom_range(0, 5) == 0) Sw_Rd = ~Sw_Rd;
    end
  end

  // Monitor
  logic step_q = 1'b0;
  logic jr = 1'b0, kr = 1'b0;
  int   width = 0;
  always @(negedge Clk) begin
    exp_t e;
    checks++;
    if (Sd !== h_sd2 || Rd !== h_rd2 || Sd2 !== h_sd2 || Rd2 !== h_rd2) begin
      errors++;
      $display("FAIL sd_rd cyc=%0d got Sd=%b Rd=%b Sd2=%b Rd2=%b exp Sd=%b Rd=%b",
               cyc, Sd, Rd, Sd2, Rd2, h_sd2, h_rd2);
    end
    if (Step && !step_q) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step cyc=%0d got Step=1 exp no pulse", cyc);
      end else begin
        e = q.pop_front();
        if (J !== e.j || K !== e.k || J2 !== e.j || K2 !== e.k || Step2 !== 1'b1 ||
            Press_cnt !== 8'(e.cnt) || Press_cnt2 !== 2'(e.cnt) || cyc != e.rise) begin
          errors++;
          $display("FAIL step_rise got cyc=%0d J=%b K=%b cnt=%0d cnt2=%0d Step2=%b exp cyc=%0d J=%b K=%b cnt=%0d cnt2=%0d",
                   cyc, J, K, Press_cnt, Press_cnt2, Step2, e.rise, e.j, e.k,
                   e.cnt % 256, e.cnt % 4);
        end
      end
      width = 1; jr = J; kr = K;
    end else if (Step && step_q) begin
      width++;
    end else if (!Step && step_q) begin
      if (!aborted) begin
        checks++;
        if (width != PW || J !== jr || K !== kr) begin
          errors++;
          $display("FAIL step_width cyc=%0d got width=%0d J=%b K=%b exp width=%0d J=%b K=%b",
                   cyc, width, J, K, PW, jr, kr);
        end
      end
      aborted = 0;
    end
    step_q = Step;
  end

  initial begin
    repeat (80000) @(posedge Clk);
    $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic push_exp(input int c);
    exp_t e;
    model_cnt++;
    e.j = Sw_J; e.k = Sw_K; e.cnt = model_cnt; e.rise = c + DEB + 4;
    q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (Busy !== 1'b0 || Busy2 !== 1'b0 || Step !== 1'b0) begin
      errors++;
      $display("FAIL %s cyc=%0d got Busy=%b Busy2=%b Step=%b exp 0 0 0", name, cyc, Busy, Busy2, Step);
    end
  endtask

  // A press is accepted once the key has been sampled low DEB+1 times in a row.
  task automatic press(input int hold, input bit glitch, input bit toggle,
                       input logic j, input logic k);
    int c;
    Sw_J = j; Sw_K = k;
    tick(4);
    c = cyc;
    Key_n = 1'b0;
    push_exp(c);
    for (int i = 0; i < hold; i++) begin
      if (toggle && i == DEB + 5) begin
        Sw_J = ~Sw_J;
        Sw_K = 1'($urandom_range(0, 1));
      end
      tick(1);
    end
    if (glitch) begin
      Key_n = 1'b1;
      tick($urandom_range(1, DEB));
      Key_n = 1'b0;
      tick(6);
    end
    Key_n = 1'b1;
    tick(DEB + 12);
    check_idle("press_done_idle");
  endtask

  task automatic bounce();
    repeat (5) begin
      Key_n = 1'b0; tick(3);
      Key_n = 1'b1; tick(1);
    end
    tick(DEB + 12);
    check_idle("bounce_idle");
  endtask

  task automatic near_miss();
    Key_n = 1'b0; tick(DEB);
    Key_n = 1'b1; tick(DEB + 12);
    check_idle("near_miss_idle");
  endtask

  task automatic reset_mid();
    int c;
    Sw_J = 1'b1; Sw_K = 1'b1;
    tick(4);
    c = cyc;
    Key_n = 1'b0;
    push_exp(c);
    tick(13);
    aborted = 1;
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    model_cnt = 0;
    checks++;
    if (Step !== 1'b0 || Press_cnt !== 8'd0 || Press_cnt2 !== 2'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got Step=%b cnt=%0d cnt2=%0d Busy=%b exp 0 0 0 0",
               Step, Press_cnt, Press_cnt2, Busy);
    end
    push_exp(cyc);
    tick(30);
    Key_n = 1'b1;
    tick(DEB + 12);
    check_idle("reset_mid_idle");
  endtask

  initial begin
    int r, hold;
    tick(2);
    checks++;
    if (Step !== 1'b0 || J !== 1'b0 || K !== 1'b0 || Sd !== 1'b1 || Rd !== 1'b1 ||
        Busy !== 1'b0 || Press_cnt !== 8'd0 || Press_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got Step=%b J=%b K=%b Sd=%b Rd=%b Busy=%b cnt=%0d exp 0 0 0 1 1 0 0",
               Step, J, K, Sd, Rd, Busy, Press_cnt);
    end
    Rst = 1'b0;
    sw_go = 1;
    tick(3);

    press(30, 0, 0, 1'b1, 1'b0);
    bounce();
    near_miss();
    press(DEB + 1, 0, 0, 1'b1, 1'b1);
    press(30, 0, 1, 1'b1, 1'b1);
    press(30, 0, 0, 1'b0, 1'b1);
    press(30, 1, 0, 1'b0, 1'b0);
    reset_mid();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 5);
      if (r == 0) bounce();
      else if (r == 1) near_miss();
      else begin
        hold = $urandom_range(DEB + 1, 40);
        press(hold, (hold >= 20) && ($urandom_range(0, 1) == 1),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got pending=%0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
